// File: rtl/vex_pkg.sv
// Shared definitions for the banked exercise-value store and its readers and writers.
// No logic, so there is no latency.
// Holds only types, constants and node-to-bank/word address helpers.
package vex_pkg;

  localparam int NUM_BANKS  = 64;
  localparam int BANK_SEL_W = 6;
  localparam int ADDR_W     = 10;
  localparam int IDX_W      = 14;
  localparam int DATA_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // One buffered stream beat.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } beat_t;

  // The low bits pick the bank, so consecutive nodes land in different banks.
  function automatic logic [BANK_SEL_W-1:0] node_bank(input logic [IDX_W-1:0] n);
    return n[BANK_SEL_W-1:0];
  endfunction

  // The remaining bits are the word address inside the bank.
  function automatic logic [ADDR_W-1:0] node_word(input logic [IDX_W-1:0] n);
    return ADDR_W'(n[IDX_W-1:BANK_SEL_W]);
  endfunction

endpackage

// File: rtl/vex_credit_fifo.sv
// Synchronous FIFO that buffers reader beats and reports its occupancy for credit accounting.
// One cycle from write to visible head; the head is read combinationally from storage.
// Never overflows by construction, because the upstream credit logic caps writes; a write into a full FIFO is ignored.
module vex_credit_fifo #(
  parameter  int WIDTH = 79,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign rd_vld = (occ != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld && (occ != OCC_W'(DEPTH));
  assign pop    = rd_rdy && rd_vld;

  // Storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/vex_stream_reader.sv
// Sweeps node range [lo, hi] out of the banked exercise-value store into an ordered valid/ready stream.
// Latency: rden one cycle after start, first beat RAM_LAT+2 cycles after start, then one beat per cycle.
// Backpressure: a credit counter stops reads once in-flight reads plus buffered beats reach FIFO_DEPTH. Optional VEX_STREAM_REVERSE_EN adds a dir input for descending sweeps.
module vex_stream_reader #(
  parameter int NUM_NODES  = 8000,
  parameter int NUM_BANKS  = 64,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [vex_pkg::IDX_W-1:0]       lo,
  input  logic [vex_pkg::IDX_W-1:0]       hi,
  output logic [vex_pkg::ADDR_W-1:0]      rdaddr,
  output logic [NUM_BANKS-1:0]            rden,
  input  logic [NUM_BANKS*vex_pkg::DATA_W-1:0] rddata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [vex_pkg::DATA_W-1:0]      out_data,
  output logic [vex_pkg::IDX_W-1:0]       out_index,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
`ifdef VEX_STREAM_REVERSE_EN
  ,
  input  logic                            dir
`endif
);

  import vex_pkg::*;

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = 8;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_NODES - 1);

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      fin_idx;
  logic                  rev_q;
  logic                  rev_start;

  logic [IDX_W-1:0]      hi_eff;
  logic                  range_empty;
  logic [IDX_W-1:0]      first_idx;
  logic [IDX_W-1:0]      final_new;

  logic                  issue;
  logic [IDX_W-1:0]      issue_idx;
  logic                  issue_last;

  logic [RAM_LAT:0]      pipe_vld;
  logic [BANK_SEL_W-1:0] pipe_sel [RAM_LAT+1];
  logic [IDX_W-1:0]      pipe_idx [RAM_LAT+1];
  logic [RAM_LAT:0]      pipe_last;

  logic [OCC_W-1:0]      occ;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      used;
  logic                  credit_ok;
  logic                  pop;
  beat_t                 wr_beat;
  beat_t                 head;

`ifdef VEX_STREAM_REVERSE_EN
  assign rev_start = dir;
`else
  assign rev_start = 1'b0;
`endif

  // Clamp the requested range and work out the first and final node of the sweep.
  always_comb begin
    hi_eff      = (hi > MAX_IDX) ? MAX_IDX : hi;
    range_empty = (lo > hi_eff);
    first_idx   = rev_start ? hi_eff : lo;
    final_new   = rev_start ? lo : hi_eff;
  end

  // Credit check: a pop this cycle frees its slot in time for the read issued on the same edge.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RAM_LAT; i++) inflight = inflight + CNT_W'(pipe_vld[i]);
    used      = inflight + CNT_W'(occ) - CNT_W'(pop);
    credit_ok = (used < CNT_W'(FIFO_DEPTH));
  end

  // Decide whether a read goes out on this edge and which node it targets.
  always_comb begin
    issue      = 1'b0;
    issue_idx  = ptr;
    issue_last = 1'b0;
    case (state)
      IDLE: begin
        issue      = start && !range_empty;
        issue_idx  = first_idx;
        issue_last = (first_idx == final_new);
      end
      RUN: begin
        issue      = credit_ok;
        issue_idx  = ptr;
        issue_last = (ptr == fin_idx);
      end
      default: ;
    endcase
  end

  // Sweep state machine with registered RAM controls, busy and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      fin_idx <= '0;
      rev_q   <= 1'b0;
      rdaddr  <= '0;
      rden    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      rden <= issue ? (NUM_BANKS'(1) << node_bank(issue_idx)) : '0;
      if (issue) rdaddr <= node_word(issue_idx);
      case (state)
        IDLE: begin
          if (start) begin
            if (range_empty) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              rev_q   <= rev_start;
              fin_idx <= final_new;
              ptr     <= rev_start ? first_idx - 1'b1 : first_idx + 1'b1;
              busy    <= 1'b1;
              state   <= (first_idx == final_new) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            ptr <= rev_q ? ptr - 1'b1 : ptr + 1'b1;
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank select and node index ride alongside each read until its data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      for (int i = 0; i <= RAM_LAT; i++) begin
        pipe_sel[i] <= '0;
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= issue;
      pipe_sel[0]  <= node_bank(issue_idx);
      pipe_idx[0]  <= issue_idx;
      pipe_last[0] <= issue_last;
      for (int i = 1; i <= RAM_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_sel[i]  <= pipe_sel[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign wr_beat.data = rddata[int'(pipe_sel[RAM_LAT])*DATA_W +: DATA_W];
  assign wr_beat.idx  = pipe_idx[RAM_LAT];
  assign wr_beat.last = pipe_last[RAM_LAT];

  vex_credit_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (pipe_vld[RAM_LAT]),
    .wr_dat (wr_beat),
    .rd_rdy (out_ready),
    .rd_vld (out_valid),
    .rd_dat (head),
    .occ    (occ)
  );

  assign pop       = out_valid && out_ready;
  assign out_data  = head.data;
  assign out_index = head.idx;
  assign out_last  = head.last;

endmodule

// File: tb/tb_vex_stream_reader.sv
// Directed bench for vex_stream_reader with a two-cycle banked RAM model returning node index as data.
// Cycle k of a sweep is the interval after the k-th edge following the start edge.
// Each scenario task compares its own results and steps the shared error/check counters.
module tb_vex_stream_reader;

  logic          clk;
  logic          rst;
  logic          start;
  logic [13:0]   lo;
  logic [13:0]   hi;
  logic          dir;
  logic [9:0]    rdaddr;
  logic [63:0]   rden;
  logic [4095:0] rddata;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [13:0]   out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  vex_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lo        (lo),
    .hi        (hi),
    .rdaddr    (rdaddr),
    .rden      (rden),
    .rddata    (rddata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef VEX_STREAM_REVERSE_EN
    ,
    .dir       (dir)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: data appears two cycles after rden, only on enabled banks.
  logic [63:0] s1_en, s2_en;
  logic [9:0]  s1_addr, s2_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_en <= '0; s2_en <= '0; s1_addr <= '0; s2_addr <= '0;
    end else begin
      s1_en <= rden; s1_addr <= rdaddr;
      s2_en <= s1_en; s2_addr <= s1_addr;
    end
  end
  always_comb begin
    rddata = '0;
    for (int b = 0; b < 64; b++)
      rddata[b*64 +: 64] = s2_en[b] ? (64'(s2_addr) * 64'd64 + 64'(b))
                                    : (64'hBAD0_0000_0000_0000 + 64'(b));
  end

  // Sweep log filled by run_sweep.
  int          b_idx[$];
  int          b_cyc[$];
  logic [63:0] b_dat[$];
  logic        b_last[$];
  int          r_cyc[$];
  int          r_bank[$];
  int          r_addr[$];
  int          done_cyc, busy_rise, busy_fall, stall_bad, max_out, onehot_bad;

  function automatic int bank_of(input logic [63:0] v);
    int r = -1;
    for (int i = 0; i < 64; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    return (mode == 0) ? 1'b1 : ((k % 3) == 1);
  endfunction

  // Pulses start, then logs everything the DUT does until done or the cycle budget runs out.
  task automatic run_sweep(input logic [13:0] l, input logic [13:0] h, input logic d,
                           input int mode, input int budget, input int inj);
    int issued, accepted;
    logic prev_stall, hold_last;
    logic [63:0] hold_dat;
    logic [13:0] hold_idx;
    b_idx.delete(); b_cyc.delete(); b_dat.delete(); b_last.delete();
    r_cyc.delete(); r_bank.delete(); r_addr.delete();
    done_cyc = -1; busy_rise = -1; busy_fall = -1;
    stall_bad = 0; max_out = 0; onehot_bad = 0;
    issued = 0; accepted = 0; prev_stall = 1'b0;
    hold_dat = '0; hold_idx = '0; hold_last = 1'b0;
    @(posedge clk); #1;
    lo = l; hi = h; dir = d; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = ready_for(mode, 1);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (rden != '0) begin
        issued++;
        if ($countones(rden) != 1) onehot_bad++;
        r_cyc.push_back(k); r_bank.push_back(bank_of(rden)); r_addr.push_back(int'(rdaddr));
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (prev_stall && (!out_valid || out_data !== hold_dat || out_index !== hold_idx
                         || out_last !== hold_last)) stall_bad++;
      if (out_valid && out_ready) begin
        b_idx.push_back(int'(out_index)); b_cyc.push_back(k);
        b_dat.push_back(out_data); b_last.push_back(out_last);
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      hold_dat = out_data; hold_idx = out_index; hold_last = out_last;
      if (busy && busy_rise < 0) busy_rise = k;
      if (!busy && busy_rise >= 0 && busy_fall < 0) busy_fall = k;
      if (done) begin
        done_cyc = k;
        break;
      end
      @(posedge clk); #1;
      out_ready = ready_for(mode, k + 1);
      start = (k + 1 == inj);
      if (k + 1 == inj) begin
        lo = 14'd0; hi = 14'd5;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; lo = '0; hi = '0; dir = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rdaddr, rden, out_valid, out_data, out_index, out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rden=%h rdaddr=%0d valid=%b busy=%b done=%b, required all 0",
               rden, rdaddr, out_valid, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int bad_idx, bad_dat, bad_cyc, bad_last, bad_bank;
    run_sweep(14'd0, 14'd127, 1'b0, 0, 300, -1);
    bad_idx = 0; bad_dat = 0; bad_cyc = 0; bad_last = 0; bad_bank = 0;
    checks++;
    if (b_idx.size() != 128) begin
      errors++; $display("FAIL basic_count: got %0d beats, required 128", b_idx.size());
    end
    foreach (b_idx[i]) begin
      if (b_idx[i] != i) bad_idx++;
      if (b_dat[i] !== 64'(i)) bad_dat++;
      if (b_cyc[i] != 4 + i) bad_cyc++;
      if (b_last[i] !== (i == 127)) bad_last++;
    end
    foreach (r_bank[i]) if (r_bank[i] != i % 64 || r_cyc[i] != 1 + i) bad_bank++;
    checks++;
    if (bad_idx != 0) begin errors++; $display("FAIL basic_order: %0d bad indices, required 0", bad_idx); end
    checks++;
    if (bad_dat != 0) begin errors++; $display("FAIL basic_data: %0d bad data, required 0", bad_dat); end
    checks++;
    if (bad_cyc != 0) begin errors++; $display("FAIL basic_timing: %0d beats off cycle 4+i, required 0", bad_cyc); end
    checks++;
    if (bad_last != 0) begin errors++; $display("FAIL basic_last: %0d bad last flags, required 0", bad_last); end
    checks++;
    if (r_bank.size() != 128 || bad_bank != 0) begin
      errors++; $display("FAIL basic_rden: %0d reads, %0d bad, required 128 and 0", r_bank.size(), bad_bank);
    end
    checks++;
    if (r_addr.size() != 128 || r_addr[0] != 0 || r_addr[63] != 0 || r_addr[64] != 1) begin
      errors++; $display("FAIL basic_rdaddr: size %0d, required words 0..0 then 1 at node 64", r_addr.size());
    end
    checks++;
    if (done_cyc != 132) begin errors++; $display("FAIL basic_done: cycle %0d, required 132", done_cyc); end
    checks++;
    if (busy_rise != 1 || busy_fall != 132) begin
      errors++; $display("FAIL basic_busy: rise %0d fall %0d, required 1 and 132", busy_rise, busy_fall);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done=%b busy=%b after pulse, required 0 0", done, busy);
    end
  endtask

  task automatic test_cross_bank();
    int exp_bank[8] = '{60, 61, 62, 63, 0, 1, 2, 3};
    int exp_addr[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int bad_r, bad_b;
    run_sweep(14'd60, 14'd67, 1'b0, 0, 100, -1);
    bad_r = 0; bad_b = 0;
    if (r_bank.size() != 8) bad_r = 99;
    else foreach (exp_bank[i]) if (r_bank[i] != exp_bank[i] || r_addr[i] != exp_addr[i]) bad_r++;
    if (b_idx.size() != 8) bad_b = 99;
    else foreach (b_idx[i]) if (b_idx[i] != 60 + i || b_dat[i] !== 64'(60 + i) || b_last[i] !== (i == 7)) bad_b++;
    checks++;
    if (bad_r != 0) begin errors++; $display("FAIL cross_rden: %0d bad bank/word steps, required 0", bad_r); end
    checks++;
    if (bad_b != 0) begin errors++; $display("FAIL cross_beats: %0d bad beats, required 0", bad_b); end
    checks++;
    if (done_cyc != 12) begin errors++; $display("FAIL cross_done: cycle %0d, required 12", done_cyc); end
  endtask

  task automatic test_backpressure();
    int bad_b;
    run_sweep(14'd0, 14'd31, 1'b0, 1, 400, -1);
    bad_b = 0;
    checks++;
    if (b_idx.size() != 32) begin errors++; $display("FAIL bp_count: got %0d beats, required 32", b_idx.size()); end
    foreach (b_idx[i]) if (b_idx[i] != i || b_dat[i] !== 64'(i) || b_last[i] !== (i == 31)) bad_b++;
    checks++;
    if (bad_b != 0) begin errors++; $display("FAIL bp_order: %0d bad beats, required 0", bad_b); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable stall cycles, required 0", stall_bad); end
    checks++;
    if (max_out > 4) begin errors++; $display("FAIL bp_outstanding: max %0d, required at most 4", max_out); end
    checks++;
    if (onehot_bad != 0 || r_cyc.size() != 32) begin
      errors++; $display("FAIL bp_reads: %0d reads, %0d not one-hot, required 32 and 0", r_cyc.size(), onehot_bad);
    end
    checks++;
    if (b_cyc.size() == 0 || done_cyc != b_cyc[b_cyc.size()-1] + 1) begin
      errors++; $display("FAIL bp_done: done cycle %0d, required one after last accept", done_cyc);
    end
  endtask

  task automatic test_empty_and_clamp();
    int bad_b;
    run_sweep(14'd10, 14'd5, 1'b0, 0, 20, -1);
    checks++;
    if (done_cyc != 1) begin errors++; $display("FAIL empty_done: cycle %0d, required 1", done_cyc); end
    checks++;
    if (r_cyc.size() != 0 || b_idx.size() != 0 || busy_rise != -1) begin
      errors++; $display("FAIL empty_quiet: %0d reads %0d beats busy at %0d, required 0 0 -1",
                         r_cyc.size(), b_idx.size(), busy_rise);
    end
    run_sweep(14'd7990, 14'd9000, 1'b0, 0, 100, -1);
    bad_b = 0;
    checks++;
    if (b_idx.size() != 10) begin errors++; $display("FAIL clamp_count: got %0d beats, required 10", b_idx.size()); end
    foreach (b_idx[i]) if (b_idx[i] != 7990 + i || b_dat[i] !== 64'(7990 + i) || b_last[i] !== (i == 9)) bad_b++;
    checks++;
    if (bad_b != 0) begin errors++; $display("FAIL clamp_beats: %0d bad beats, required 0", bad_b); end
    checks++;
    if (done_cyc != 14) begin errors++; $display("FAIL clamp_done: cycle %0d, required 14", done_cyc); end
  endtask

  task automatic test_reset_mid();
    int bad_b;
    // Sweep 200..299 with a stray start in cycle 10; stop watching after cycle 20.
    run_sweep(14'd200, 14'd299, 1'b0, 0, 20, 10);
    bad_b = 0;
    foreach (b_idx[i]) if (b_idx[i] != 200 + i || b_dat[i] !== 64'(200 + i)) bad_b++;
    checks++;
    if (b_idx.size() != 17 || bad_b != 0 || done_cyc != -1) begin
      errors++; $display("FAIL busy_start_ignored: %0d beats, %0d bad, done %0d, required 17 0 -1",
                         b_idx.size(), bad_b, done_cyc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rdaddr, rden, out_valid, out_data, out_index, out_last, busy, done} !== '0) begin
      errors++; $display("FAIL midreset_outputs: rden=%h valid=%b idx=%0d busy=%b, required all 0",
                         rden, out_valid, out_index, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(14'd500, 14'd509, 1'b0, 0, 100, -1);
    bad_b = 0;
    foreach (b_idx[i]) if (b_idx[i] != 500 + i || b_dat[i] !== 64'(500 + i) || b_cyc[i] != 4 + i) bad_b++;
    checks++;
    if (b_idx.size() != 10 || bad_b != 0) begin
      errors++; $display("FAIL fresh_sweep: %0d beats, %0d bad, required 10 and 0", b_idx.size(), bad_b);
    end
    checks++;
    if (done_cyc != 14) begin errors++; $display("FAIL fresh_done: cycle %0d, required 14", done_cyc); end
  endtask

`ifdef VEX_STREAM_REVERSE_EN
  task automatic test_reverse();
    int bad_b;
    run_sweep(14'd0, 14'd63, 1'b1, 0, 200, -1);
    bad_b = 0;
    foreach (b_idx[i]) if (b_idx[i] != 63 - i || b_dat[i] !== 64'(63 - i) || b_last[i] !== (i == 63)) bad_b++;
    checks++;
    if (b_idx.size() != 64 || bad_b != 0) begin
      errors++; $display("FAIL reverse_beats: %0d beats, %0d bad, required 64 and 0", b_idx.size(), bad_b);
    end
    checks++;
    if (r_bank.size() == 0 || r_bank[0] != 63 || done_cyc != 68) begin
      errors++; $display("FAIL reverse_timing: first bank %0d done %0d, required 63 and 68",
                         (r_bank.size() == 0) ? -1 : r_bank[0], done_cyc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_cross_bank();
    test_backpressure();
    test_empty_and_clamp();
    test_reset_mid();
`ifdef VEX_STREAM_REVERSE_EN
    test_reverse();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
